sq_req_arbiter_32: RTL and testbench

Round-robin arbiter and pipeline sequencer that shares one 32-bit `(y + 1) * (y + 1)` datapath (the `many_assigns_32` unit, ports `y`/`out`) between `NUM_REQ` requesters. It accepts at most one request per cycle over valid/ready handshakes. The request is carried with its requester tag through a `LATENCY`-stage registered pipeline. The result is returned on a single response channel with backpressure. It sits between client blocks and the shared squarer, so only one instance of the datapath is built.

---
 rtl/sq_req_arbiter_32.sv | 165 ++++++++++++++++
 tb/tb_sq_req_arbiter_32.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_req_arbiter_32.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sq_req_arbiter_32
// Round-robin arbiter that shares one (y+1)*(y+1) squarer between NUM_REQ
// requesters. One request is accepted per cycle, tagged with its requester
// index, carried through a LATENCY-deep register pipeline and returned on a
// single backpressured response channel.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   per-requester operand present
//   req_y       per-requester operand, requester i on [32i+31:32i]
//   req_ready   one-hot-or-zero grant (combinational)
//   resp_valid  response present
//   resp_ready  consumer accepts the response
//   resp_id     requester index owning the response
//   resp_out    (y+1)*(y+1) mod 2^32
//   busy        any pipeline stage holds a valid entry
// ---------------------------------------------------------------------------

// Shared datapath: out = (y + 1)^2, low 32 bits.
module many_assigns_32 (
    input  logic [31:0] y,
    output logic [31:0] out
);
    logic [31:0] y_inc;
    logic [31:0] sq;

    assign y_inc = y + 32'd1;
    assign sq    = y_inc * y_inc;
    assign out   = sq;
endmodule

module sq_req_arbiter_32 #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*32-1:0]     req_y,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [31:0]               resp_out,
    output logic                      busy
);
    localparam int unsigned DATA_W = 32;
    // One extra bit so ptr + k can be compared against NUM_REQ before wrapping.
    localparam int unsigned IDX_W  = ID_W + 1;

    // Payload carried by every pipeline stage.
    typedef struct packed {
        logic              vld;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] res;
    } stage_t;

    stage_t [LATENCY-1:0] stg_q;
    stage_t [LATENCY-1:0] stg_d;

    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      ptr_d;

    logic                 adv_c;
    logic                 scan_en_c;
    logic                 grant_any_c;
    logic [ID_W-1:0]      grant_idx_c;
    logic [NUM_REQ-1:0]   grant_oh_c;
    logic [IDX_W-1:0]     scan_idx_c;
    logic [DATA_W-1:0]    sel_y_c;
    logic [DATA_W-1:0]    sq_res_c;
    logic                 busy_c;

    // Whole pipeline moves together whenever the output slot can be vacated.
    assign adv_c     = ~stg_q[LATENCY-1].vld | resp_ready;
    assign scan_en_c = adv_c & ~rst;

    // Round-robin scan starting at ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_any_c = 1'b0;
        grant_idx_c = '0;
        scan_idx_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx_c = IDX_W'(ptr_q) + IDX_W'(k);
            if (scan_idx_c >= IDX_W'(NUM_REQ)) begin
                scan_idx_c = scan_idx_c - IDX_W'(NUM_REQ);
            end
            if (!grant_any_c && scan_en_c && req_valid[scan_idx_c[ID_W-1:0]]) begin
                grant_any_c = 1'b1;
                grant_idx_c = scan_idx_c[ID_W-1:0];
            end
        end
    end

    // One-hot grant and operand select.
    always_comb begin
        grant_oh_c = '0;
        sel_y_c    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_oh_c[i] = grant_any_c && (grant_idx_c == ID_W'(i));
            if (grant_oh_c[i]) begin
                sel_y_c = req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = grant_oh_c;

    // Pointer moves just past the granted requester.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any_c) begin
            if (grant_idx_c == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_c + ID_W'(1);
            end
        end
    end

    many_assigns_32 u_sq (
        .y   (sel_y_c),
        .out (sq_res_c)
    );

    // Stage 0 captures the grant; later stages forward. Bubbles shift too.
    always_comb begin
        stg_d = stg_q;
        if (adv_c) begin
            stg_d[0].vld = grant_any_c;
            stg_d[0].id  = grant_any_c ? grant_idx_c : '0;
            stg_d[0].res = grant_any_c ? sq_res_c : '0;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                stg_d[s] = stg_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= '0;
            ptr_q <= '0;
        end else begin
            stg_q <= stg_d;
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int unsigned s = 0; s < LATENCY; s++) begin
            busy_c = busy_c | stg_q[s].vld;
        end
    end

    assign resp_valid = stg_q[LATENCY-1].vld;
    assign resp_id    = stg_q[LATENCY-1].id;
    assign resp_out   = stg_q[LATENCY-1].res;
    assign busy       = busy_c;

endmodule

// File: tb/tb_sq_req_arbiter_32.sv
`timescale 1ns/1ps
module tb_sq_req_arbiter_32;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_y;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_out;
    logic                  busy;

    sq_req_arbiter_32 #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Handshake logs, sampled mid-cycle (handshake completes at the next rising edge).
    int          cyc = 0;
    int          g_id_q[$];
    int          g_cyc_q[$];
    int          r_id_q[$];
    int          r_cyc_q[$];
    logic [31:0] r_val_q[$];
    int          g_seen = 0;

    always @(negedge clk) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_valid[i] && req_ready[i]) begin
                g_id_q.push_back(i);
                g_cyc_q.push_back(cyc);
            end
        end
        if (resp_valid && resp_ready) begin
            r_id_q.push_back(int'(resp_id));
            r_val_q.push_back(resp_out);
            r_cyc_q.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    typedef struct {
        int          req;
        logic [31:0] y;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and withdraw any request that was just accepted.
    task automatic tick_drop();
        tick();
        while (g_seen < g_id_q.size()) begin
            req_valid[g_id_q[g_seen]] = 1'b0;
            g_seen++;
        end
    endtask

    task automatic clear_logs();
        g_id_q.delete();
        g_cyc_q.delete();
        r_id_q.delete();
        r_cyc_q.delete();
        r_val_q.delete();
        g_seen = 0;
    endtask

    task automatic set_y(input int idx, input logic [31:0] v);
        req_y[idx*32 +: 32] = v;
    endtask

    initial begin
        vecs[0] = '{0, 32'd10,         32'd121};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'd0};
        vecs[2] = '{2, 32'd65535,      32'd0};
        vecs[3] = '{3, 32'd65534,      32'd4294836225};
        vecs[4] = '{0, 32'd0,          32'd1};
        vecs[5] = '{2, 32'd7,          32'd64};
        vecs[6] = '{1, 32'h0001_0000,  32'h0002_0001};
        vecs[7] = '{3, 32'h8000_0000,  32'd1};

        // Reset state, with requests and resp_ready present.
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = '1;
        req_y      = '0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_out", resp_out, 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        tick();
        clear_logs();

        // Single requests including wrap-around operands.
        for (int v = 0; v < 8; v++) begin
            clear_logs();
            req_valid = '0;
            req_valid[vecs[v].req] = 1'b1;
            set_y(vecs[v].req, vecs[v].y);
            tick();
            req_valid = '0;
            repeat (4) tick();
            chk($sformatf("v%0d_n_grant", v), 32'(g_id_q.size()), 32'd1);
            chk($sformatf("v%0d_n_resp", v), 32'(r_id_q.size()), 32'd1);
            if (g_id_q.size() > 0)
                chk($sformatf("v%0d_grant_id", v), 32'(g_id_q[0]), 32'(vecs[v].req));
            if (r_id_q.size() > 0) begin
                chk($sformatf("v%0d_resp_id", v), 32'(r_id_q[0]), 32'(vecs[v].req));
                chk($sformatf("v%0d_resp_out", v), r_val_q[0], vecs[v].exp_out);
            end
            if (r_id_q.size() > 0 && g_id_q.size() > 0)
                chk($sformatf("v%0d_latency", v), 32'(r_cyc_q[0] - g_cyc_q[0]), 32'(LATENCY));
            chk($sformatf("v%0d_busy_idle", v), 32'(busy), 32'd0);
        end

        // All four at once after a reset: grants 0..3, responses back-to-back.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        req_valid = 4'hF;
        set_y(0, 32'd3); set_y(1, 32'd4); set_y(2, 32'd5); set_y(3, 32'd6);
        for (int c = 0; c < 10 && req_valid != '0; c++) tick_drop();
        repeat (4) tick_drop();
        chk("all4_n_grant", 32'(g_id_q.size()), 32'd4);
        chk("all4_n_resp", 32'(r_id_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_id_q.size() && i < r_id_q.size(); i++) begin
            chk($sformatf("all4_grant%0d", i), 32'(g_id_q[i]), 32'(i));
            chk($sformatf("all4_resp_id%0d", i), 32'(r_id_q[i]), 32'(i));
            chk($sformatf("all4_resp_out%0d", i), r_val_q[i], 32'((i + 4) * (i + 4)));
            if (i > 0) begin
                chk($sformatf("all4_grant_gap%0d", i), 32'(g_cyc_q[i] - g_cyc_q[i-1]), 32'd1);
                chk($sformatf("all4_resp_gap%0d", i), 32'(r_cyc_q[i] - r_cyc_q[i-1]), 32'd1);
            end
        end

        // Fairness between requesters 1 and 3.
        clear_logs();
        set_y(1, 32'd1); set_y(3, 32'd2);
        req_valid = 4'b1010;
        repeat (8) tick();
        req_valid = '0;
        repeat (4) tick();
        chk("fair_n_grant", 32'(g_id_q.size()), 32'd8);
        chk("fair_n_resp", 32'(r_id_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < g_id_q.size(); i++)
            chk($sformatf("fair_grant%0d", i), 32'(g_id_q[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
        for (int i = 0; i < 8 && i < r_id_q.size(); i++)
            chk($sformatf("fair_resp_out%0d", i), r_val_q[i], (i % 2 == 0) ? 32'd4 : 32'd9);

        // Backpressure: two entries held for five stalled cycles.
        clear_logs();
        resp_ready = 1'b0;
        set_y(0, 32'd10); set_y(1, 32'd20); set_y(2, 32'd30); set_y(3, 32'd40);
        req_valid = 4'hF;
        tick_drop();
        tick_drop();
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp_req_ready%0d", s), 32'(req_ready), 32'd0);
            chk($sformatf("bp_resp_valid%0d", s), 32'(resp_valid), 32'd1);
            chk($sformatf("bp_resp_out%0d", s), resp_out, 32'd121);
            chk($sformatf("bp_resp_id%0d", s), 32'(resp_id), 32'd0);
            tick_drop();
        end
        chk("bp_grants_during_stall", 32'(g_id_q.size()), 32'd2);
        resp_ready = 1'b1;
        for (int c = 0; c < 10 && req_valid != '0; c++) tick_drop();
        repeat (4) tick_drop();
        chk("bp_n_grant", 32'(g_id_q.size()), 32'd4);
        chk("bp_n_resp", 32'(r_id_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < r_id_q.size(); i++) begin
            chk($sformatf("bp_resp_id%0d", i), 32'(r_id_q[i]), 32'(i));
            chk($sformatf("bp_resp_val%0d", i), r_val_q[i], 32'((10 * (i + 1) + 1) * (10 * (i + 1) + 1)));
        end

        // Reset with two entries in flight and requester 2 pending.
        clear_logs();
        resp_ready = 1'b0;
        set_y(0, 32'd100); set_y(1, 32'd200); set_y(2, 32'd7);
        req_valid = 4'b0011;
        tick_drop();
        tick_drop();
        req_valid[2] = 1'b1;
        tick();
        chk("rr_pending_ready", 32'(req_ready), 32'd0);
        chk("rr_busy_before", 32'(busy), 32'd1);
        chk("rr_grants_before", 32'(g_id_q.size()), 32'd2);
        rst        = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk("rr_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        clear_logs();
        req_valid = 4'b0110;
        #1;
        chk("rr_post_resp_valid", 32'(resp_valid), 32'd0);
        chk("rr_post_busy", 32'(busy), 32'd0);
        chk("rr_post_ready", 32'(req_ready), 32'b0010);
        for (int c = 0; c < 10 && req_valid != '0; c++) tick_drop();
        repeat (4) tick_drop();
        chk("rr_n_grant", 32'(g_id_q.size()), 32'd2);
        chk("rr_n_resp", 32'(r_id_q.size()), 32'd2);
        if (r_id_q.size() > 0) begin
            chk("rr_first_resp_id", 32'(r_id_q[0]), 32'd1);
            chk("rr_first_resp_out", r_val_q[0], 32'd40401);
        end
        if (r_id_q.size() > 1) begin
            chk("rr_second_resp_id", 32'(r_id_q[1]), 32'd2);
            chk("rr_second_resp_out", r_val_q[1], 32'd64);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
